// File: rtl/vga_font_fetch.sv
// Text-mode pixel generator: text RAM -> font ROM -> serialized pixel, 3-tick pipeline.
// Optional blinking underline cursor is built when the CURSOR_EN macro is defined.
module vga_font_fetch #(
    parameter int COLS = 80
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        pix_en_i,
    input  logic [9:0]  hcount_i,
    input  logic [9:0]  vcount_i,
    input  logic        video_on_i,
    input  logic        hsync_i,
    input  logic        vsync_i,
    output logic        char_en_o,
    output logic [11:0] char_addr_o,
    input  logic [7:0]  char_data_i,
    output logic        font_en_o,
    output logic [11:0] font_addr_o,
    input  logic [7:0]  font_data_i,
    output logic        pixel_o,
    output logic        video_on_o,
    output logic        hsync_o,
    output logic        vsync_o
`ifdef CURSOR_EN
    ,
    input  logic [6:0]  cursor_col_i,
    input  logic [4:0]  cursor_row_i
`endif
);

    localparam logic [11:0] COLS_W = 12'(COLS);

    logic [6:0] col_s;
    logic [4:0] row_s;
    logic       unused_vbit_s;

    logic [3:0] glyph_s1_r;
    logic [2:0] bit_s1_r;
    logic       von_s1_r, hs_s1_r, vs_s1_r;

    logic [2:0] bit_s2_r;
    logic       von_s2_r, hs_s2_r, vs_s2_r;

    logic       font_bit_s;
    logic       cursor_hit_s;
    logic       pixel_next_s;

    assign col_s         = hcount_i[9:3];
    assign row_s         = vcount_i[8:4];
    assign unused_vbit_s = vcount_i[9];

    // Memory enables fire for exactly one clock per pixel tick; reset forces them idle.
    always_comb begin
        char_en_o = pix_en_i & video_on_i & ~rst_i;
        font_en_o = pix_en_i & von_s1_r & ~rst_i;
        if (rst_i) begin
            char_addr_o = 12'd0;
            font_addr_o = 12'd0;
        end else begin
            char_addr_o = {7'd0, row_s} * COLS_W + {5'd0, col_s};
            font_addr_o = {char_data_i, glyph_s1_r};
        end
    end

    // Stage 1: position within the glyph cell plus raster flags.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            glyph_s1_r <= 4'd0;
            bit_s1_r   <= 3'd0;
            von_s1_r   <= 1'b0;
            hs_s1_r    <= 1'b1;
            vs_s1_r    <= 1'b1;
        end else if (pix_en_i) begin
            glyph_s1_r <= vcount_i[3:0];
            bit_s1_r   <= hcount_i[2:0];
            von_s1_r   <= video_on_i;
            hs_s1_r    <= hsync_i;
            vs_s1_r    <= vsync_i;
        end
    end

    // Stage 2: carries the bit index and flags until the font byte arrives.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bit_s2_r <= 3'd0;
            von_s2_r <= 1'b0;
            hs_s2_r  <= 1'b1;
            vs_s2_r  <= 1'b1;
        end else if (pix_en_i) begin
            bit_s2_r <= bit_s1_r;
            von_s2_r <= von_s1_r;
            hs_s2_r  <= hs_s1_r;
            vs_s2_r  <= vs_s1_r;
        end
    end

`ifdef CURSOR_EN
    logic [6:0] col_s1_r, col_s2_r;
    logic [4:0] row_s1_r, row_s2_r;
    logic [3:0] glyph_s2_r;
    logic [4:0] frame_cnt_r;
    logic       vsync_prev_r;

    // Cell coordinates travel with the pixel so the cursor compare lines up with stage 2.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            col_s1_r   <= 7'd0;
            row_s1_r   <= 5'd0;
            col_s2_r   <= 7'd0;
            row_s2_r   <= 5'd0;
            glyph_s2_r <= 4'd0;
        end else if (pix_en_i) begin
            col_s1_r   <= col_s;
            row_s1_r   <= row_s;
            col_s2_r   <= col_s1_r;
            row_s2_r   <= row_s1_r;
            glyph_s2_r <= glyph_s1_r;
        end
    end

    // Frame counter: bit 4 gives a 16-on / 16-off blink.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            frame_cnt_r  <= 5'd0;
            vsync_prev_r <= 1'b1;
        end else if (pix_en_i) begin
            vsync_prev_r <= vsync_i;
            if (vsync_prev_r && !vsync_i) begin
                frame_cnt_r <= frame_cnt_r + 5'd1;
            end
        end
    end

    // Cursor covers the bottom two glyph rows of the matching in-range cell.
    always_comb begin
        if ((cursor_col_i < 7'(COLS)) && (cursor_row_i < 5'd30) &&
            (col_s2_r == cursor_col_i) && (row_s2_r == cursor_row_i) &&
            (glyph_s2_r[3:1] == 3'b111) && frame_cnt_r[4]) begin
            cursor_hit_s = 1'b1;
        end else begin
            cursor_hit_s = 1'b0;
        end
    end
`else
    assign cursor_hit_s = 1'b0;
`endif

    assign font_bit_s   = font_data_i[3'd7 - bit_s2_r];
    assign pixel_next_s = (font_bit_s ^ cursor_hit_s) & von_s2_r;

    // Output register: pixel and raster flags leave together.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pixel_o    <= 1'b0;
            video_on_o <= 1'b0;
            hsync_o    <= 1'b1;
            vsync_o    <= 1'b1;
        end else if (pix_en_i) begin
            pixel_o    <= pixel_next_s;
            video_on_o <= von_s2_r;
            hsync_o    <= hs_s2_r;
            vsync_o    <= vs_s2_r;
        end
    end

endmodule

// File: tb/tb_vga_font_fetch.sv
// Randomized self-checking bench for vga_font_fetch against a tick-level reference model.
module tb_vga_font_fetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, pe, von, hs, vs;
    logic [9:0]  hc, vc;
    logic        char_en, font_en;
    logic [11:0] char_addr, font_addr;
    logic [7:0]  char_data = 8'd0;
    logic [7:0]  font_data = 8'd0;
    logic        pixel, von_o, hs_o, vs_o;
`ifdef CURSOR_EN
    logic [6:0]  ccol = 7'd5;
    logic [4:0]  crow = 5'd2;
`endif

    logic [7:0] ram [0:4095];
    logic [7:0] rom [0:4095];

    vga_font_fetch #(.COLS(80)) dut (
        .clk_i(clk), .rst_i(rst), .pix_en_i(pe),
        .hcount_i(hc), .vcount_i(vc), .video_on_i(von),
        .hsync_i(hs), .vsync_i(vs),
        .char_en_o(char_en), .char_addr_o(char_addr), .char_data_i(char_data),
        .font_en_o(font_en), .font_addr_o(font_addr), .font_data_i(font_data),
        .pixel_o(pixel), .video_on_o(von_o), .hsync_o(hs_o), .vsync_o(vs_o)
`ifdef CURSOR_EN
        , .cursor_col_i(ccol), .cursor_row_i(crow)
`endif
    );

    // Synchronous memories: data appears the clock after the enable.
    always @(posedge clk) begin
        if (char_en) char_data <= ram[char_addr];
        if (font_en) font_data <= rom[font_addr];
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [9:0] hc;
        logic [9:0] vc;
        logic       von;
        logic       hs;
        logic       vs;
    } rec_t;

    rec_t       hist[$];
    logic       exp_pix = 1'b0, exp_von = 1'b0, exp_hs = 1'b1, exp_vs = 1'b1;
    bit         armed = 1'b0;
    logic [4:0] fc = 5'd0;
    logic       pvs = 1'b1;

    function automatic logic [11:0] addr_of(rec_t r);
        return 12'(int'(r.vc[8:4]) * 80 + int'(r.hc[9:3]));
    endfunction

    function automatic logic pix_of(rec_t r);
        logic [7:0] code;
        logic [7:0] glyph;
        logic       b;
        if (!r.von) return 1'b0;
        code  = ram[addr_of(r)];
        glyph = rom[{code, r.vc[3:0]}];
        b     = glyph[7 - int'(r.hc[2:0])];
`ifdef CURSOR_EN
        if (int'(r.hc[9:3]) == int'(ccol) && int'(r.vc[8:4]) == int'(crow) &&
            ccol < 7'd80 && crow < 5'd30 && r.vc[3:0] >= 4'd14 && fc[4])
            b = ~b;
`endif
        return b;
    endfunction

    // One clock: check outputs mid-cycle, then advance the model on the edge.
    task automatic cycle();
        rec_t cur;
        rec_t last;
        logic fe_exp;
        cur = '{hc: hc, vc: vc, von: von, hs: hs, vs: vs};
        @(negedge clk);
        if (rst) begin
            check("rst_char_en", char_en, 1'b0);
            check("rst_font_en", font_en, 1'b0);
            check("rst_char_addr", char_addr, 12'd0);
            check("rst_font_addr", font_addr, 12'd0);
        end else begin
            check("char_en", char_en, pe & von);
            if (pe & von) check("char_addr", char_addr, addr_of(cur));
            fe_exp = 1'b0;
            if (hist.size() > 0) begin
                last   = hist[hist.size()-1];
                fe_exp = pe & last.von;
            end
            check("font_en", font_en, fe_exp);
            if (fe_exp) check("font_addr", font_addr, {ram[addr_of(last)], last.vc[3:0]});
        end
        if (armed) begin
            check("pixel", pixel, exp_pix);
            check("video_on", von_o, exp_von);
            check("hsync", hs_o, exp_hs);
            check("vsync", vs_o, exp_vs);
        end
        @(posedge clk);
        if (rst) begin
            hist.delete();
            exp_pix = 1'b0; exp_von = 1'b0; exp_hs = 1'b1; exp_vs = 1'b1;
            fc = 5'd0; pvs = 1'b1; armed = 1'b1;
        end else if (pe) begin
            hist.push_back(cur);
            if (hist.size() > 3) void'(hist.pop_front());
            if (hist.size() == 3) begin
                exp_pix = pix_of(hist[0]);
                exp_von = hist[0].von;
                exp_hs  = hist[0].hs;
                exp_vs  = hist[0].vs;
            end
            if (pvs && !vs) fc = fc + 5'd1;
            pvs = vs;
        end
        #1;
    endtask

    task automatic drive(input logic p, input int h, input int v, input logic o);
        pe = p; hc = 10'(h); vc = 10'(v); von = o;
    endtask

    logic [7:0] row_pat;

    initial begin
        for (int i = 0; i < 4096; i++) begin
            ram[i] = 8'($urandom);
            rom[i] = 8'($urandom);
        end
        ram[0]        = 8'h41;
        rom[12'h410]  = 8'h81;
        ram[2*80+5]   = 8'h20;
        rom[12'h20E]  = 8'h00;
        row_pat       = 8'h81;

        rst = 1'b1; hs = 1'b1; vs = 1'b1;
        drive(1'b0, 0, 0, 1'b0);
        cycle(); cycle();
        rst = 1'b0;

        // Pixel row from 'A' glyph with one tick per clock
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, i, 0, 1'b1);
            cycle();
            if (i == 0) check("row_font_addr", font_addr, 12'h410);
            if (i >= 2 && i < 10) check("row_pix", pixel, row_pat[9 - i]);
        end

        // Bottom-right cell
        drive(1'b1, 639, 479, 1'b1);
        #1 check("corner_char_addr", char_addr, 12'h95F);
        cycle();
        check("corner_glyph_row", font_addr[3:0], 4'hF);
        for (int i = 0; i < 3; i++) begin drive(1'b1, i, 0, 1'b1); cycle(); end

        // Blanking with an hsync pulse travelling through the pipe
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 640 + i, 100, 1'b0);
            hs = (i == 2) ? 1'b0 : 1'b1;
            cycle();
            if (i == 4) check("hsync_delay", hs_o, 1'b0);
            if (i == 5) check("hsync_after", hs_o, 1'b1);
        end
        hs = 1'b1;

        // Sparse ticks: one tick every 4th clock
        for (int k = 0; k < 96; k++) begin
            drive((k % 4) == 0, 16 + k / 4, 33, 1'b1);
            cycle();
        end

        // Reset mid-line at hcount 300
        for (int h = 292; h <= 300; h++) begin drive(1'b1, h, 200, 1'b1); cycle(); end
        rst = 1'b1; pe = 1'($urandom); hs = 1'b0; vs = 1'b0;
        cycle();
        check("mid_rst_pixel", pixel, 1'b0);
        check("mid_rst_hsync", hs_o, 1'b1);
        check("mid_rst_vsync", vs_o, 1'b1);
        check("mid_rst_char_en", char_en, 1'b0);
        check("mid_rst_font_en", font_en, 1'b0);
        rst = 1'b0; hs = 1'b1; vs = 1'b1;
        for (int h = 0; h < 6; h++) begin
            drive(1'b1, 8 + h, 0, 1'b1);
            cycle();
            if (h == 1) check("post_rst_blank", von_o, 1'b0);
            if (h == 2) check("post_rst_first", von_o, 1'b1);
        end

        // Randomized raster, tick density and occasional reset
        for (int k = 0; k < 2000; k++) begin
            int hh, vv;
            hh  = int'($urandom_range(0, 799));
            vv  = int'($urandom_range(0, 524));
            drive(($urandom % 3) != 0, hh, vv, (hh < 640) && (vv < 480));
            hs  = ($urandom % 8) != 0;
            vs  = ($urandom % 6) != 0;
            rst = ($urandom % 150) == 0;
            cycle();
        end
        rst = 1'b0; hs = 1'b1; vs = 1'b1;

`ifdef CURSOR_EN
        rst = 1'b1; cycle(); rst = 1'b0;
        for (int pass = 0; pass < 2; pass++) begin
            for (int f = 0; f < 16; f++) begin
                drive(1'b1, 700, 490, 1'b0);
                vs = 1'b1; cycle();
                vs = 1'b0; cycle();
            end
            vs = 1'b1;
            for (int i = 0; i < 11; i++) begin
                drive(1'b1, 40 + i, 46, 1'b1);
                cycle();
                if (i >= 2 && i < 10) check(pass == 0 ? "cursor_on" : "cursor_off", pixel, pass == 0 ? 1'b1 : 1'b0);
            end
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
